// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if
// Bundles the instruction handshake, the two register-file read ports, the
// register-file write port and the status outputs of the execute stage.
//   master : environment side (sequencer + register file) - drives the
//            instruction and the read data, observes everything else
//   slave  : execute-stage side - the mirror image
// Signals:
//   instr_valid/instr_ready, op[2:0], rd/rs/rt[4:0]   instruction handshake
//   rdAddrA/rdAddrB[4:0] -> rdDataA/rdDataB[15:0]       read ports
//   write, wrAddr[4:0], wrData[15:0]                     write port
//   done, flag_z, flag_c                                 status to sequencer
interface alu_exec_stage_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rdAddrA;
    logic [15:0] rdDataA;
    logic [4:0]  rdAddrB;
    logic [15:0] rdDataB;
    logic        write;
    logic [4:0]  wrAddr;
    logic [15:0] wrData;
    logic        done;
    logic        flag_z;
    logic        flag_c;

    modport master (
        output instr_valid, op, rd, rs, rt, rdDataA, rdDataB,
        input  instr_ready, rdAddrA, rdAddrB, write, wrAddr, wrData, done, flag_z, flag_c
    );

    modport slave (
        input  instr_valid, op, rd, rs, rt, rdDataA, rdDataB,
        output instr_ready, rdAddrA, rdAddrB, write, wrAddr, wrData, done, flag_z, flag_c
    );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage
// Multi-cycle execute/write-back stage in front of a 32 x 16-bit register file.
// Accepts one register-register instruction at a time, reads both operands,
// computes a 16-bit result (single-cycle ALU op or 16-step shift-add multiply)
// and writes it back, then reports zero/carry flags and a done pulse.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    alu_exec_stage_if.slave (handshake, read ports, write port, status)
module alu_exec_stage (
    input  logic              clk,
    input  logic              reset,
    alu_exec_stage_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpSll = 3'b101,
        OpSrl = 3'b110,
        OpMul = 3'b111
    } op_e;

    state_e      state_q, state_d;
    op_e         op_q;
    logic [4:0]  rd_q;
    logic [15:0] op_a_q;
    logic [15:0] op_b_q;      // doubles as the multiplier, shifted right each MUL step
    logic [31:0] mcand_q;
    logic [31:0] product_q;
    logic [3:0]  count_q;
    logic        carry_q;

    logic [31:0] prod_nxt;
    logic [15:0] alu_res;
    logic        alu_c;

    assign bus.instr_ready = (state_q == StIdle);

    // One shift-add step of the multiply.
    assign prod_nxt = op_b_q[0] ? (product_q + mcand_q) : product_q;

    always_comb begin
        alu_res = 16'h0000;
        alu_c   = 1'b0;
        unique case (op_q)
            OpAdd: {alu_c, alu_res} = {1'b0, op_a_q} + {1'b0, op_b_q};
            OpSub: begin
                alu_res = op_a_q - op_b_q;
                alu_c   = (op_a_q < op_b_q);
            end
            OpAnd: alu_res = op_a_q & op_b_q;
            OpOr:  alu_res = op_a_q | op_b_q;
            OpXor: alu_res = op_a_q ^ op_b_q;
            OpSll: alu_res = op_a_q << op_b_q[3:0];
            OpSrl: alu_res = op_a_q >> op_b_q[3:0];
            OpMul: begin
                // Only meaningful on the last step, when prod_nxt is the full product.
                alu_res = prod_nxt[15:0];
                alu_c   = |prod_nxt[31:16];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.instr_valid) state_d = StRead;
            StRead: state_d = StExec;
            StExec: if (op_q != OpMul || count_q == 4'd15) state_d = StWb;
            StWb:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= OpAdd;
            rd_q        <= 5'd0;
            op_a_q      <= 16'h0000;
            op_b_q      <= 16'h0000;
            mcand_q     <= 32'h0;
            product_q   <= 32'h0;
            count_q     <= 4'd0;
            carry_q     <= 1'b0;
            bus.rdAddrA <= 5'd0;
            bus.rdAddrB <= 5'd0;
            bus.write   <= 1'b0;
            bus.done    <= 1'b0;
            bus.wrAddr  <= 5'd0;
            bus.wrData  <= 16'h0000;
            bus.flag_z  <= 1'b0;
            bus.flag_c  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.instr_valid) begin
                        op_q        <= op_e'(bus.op);
                        rd_q        <= bus.rd;
                        bus.rdAddrA <= bus.rs;
                        bus.rdAddrB <= bus.rt;
                    end
                end
                StRead: begin
                    op_a_q <= bus.rdDataA;
                    op_b_q <= bus.rdDataB;
                    if (op_q == OpMul) begin
                        product_q <= 32'h0;
                        mcand_q   <= {16'h0000, bus.rdDataA};
                        count_q   <= 4'd0;
                    end
                end
                StExec: begin
                    if (op_q == OpMul) begin
                        product_q <= prod_nxt;
                        mcand_q   <= mcand_q << 1;
                        op_b_q    <= op_b_q >> 1;
                        count_q   <= count_q + 4'd1;
                    end
                    if (state_d == StWb) begin
                        bus.wrAddr <= rd_q;
                        bus.wrData <= alu_res;
                        carry_q    <= alu_c;
                        // r0 writes are dropped but still reported as done.
                        bus.write  <= (rd_q != 5'd0);
                        bus.done   <= 1'b1;
                    end
                end
                StWb: begin
                    bus.write  <= 1'b0;
                    bus.done   <= 1'b0;
                    bus.flag_z <= (bus.wrData == 16'h0000);
                    bus.flag_c <= carry_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

    logic clk = 1'b0;
    logic reset;

    alu_exec_stage_if bus ();

    alu_exec_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file model: combinational reads, write at the rising edge.
    logic [15:0] rf [32];
    logic        rf_clr;
    logic        pre_we;
    logic [4:0]  pre_addr;
    logic [15:0] pre_data;

    assign bus.rdDataA = rf[bus.rdAddrA];
    assign bus.rdDataB = rf[bus.rdAddrB];

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= 16'h0000;
        end else begin
            if (bus.write) rf[bus.wrAddr] <= bus.wrData;
            if (pre_we) rf[pre_addr] <= pre_data;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [15:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    // Issue one instruction at the current (ready) cycle T, hold instr_valid high
    // while busy, check the write-back at T+lat and the flags at T+lat+1.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [4:0] d,
                          input logic [4:0] s, input logic [4:0] t,
                          input logic [15:0] exp_data, input logic exp_z,
                          input logic exp_c, input int lat);
        chk({tag, " ready_before"}, 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.op = o;
        bus.rd = d;
        bus.rs = s;
        bus.rt = t;
        tick();
        for (int i = 1; i < lat; i++) begin
            chk({tag, " ready_busy"}, 32'(bus.instr_ready), 32'd0);
            chk({tag, " write_early"}, 32'(bus.write), 32'd0);
            tick();
        end
        chk({tag, " write"}, 32'(bus.write), 32'(d != 5'd0));
        chk({tag, " done"}, 32'(bus.done), 32'd1);
        chk({tag, " wrAddr"}, 32'(bus.wrAddr), 32'(d));
        chk({tag, " wrData"}, 32'(bus.wrData), 32'(exp_data));
        chk({tag, " ready_wb"}, 32'(bus.instr_ready), 32'd0);
        chk({tag, " rdAddrA"}, 32'(bus.rdAddrA), 32'(s));
        chk({tag, " rdAddrB"}, 32'(bus.rdAddrB), 32'(t));
        bus.instr_valid = 1'b0;
        tick();
        chk({tag, " ready_after"}, 32'(bus.instr_ready), 32'd1);
        chk({tag, " write_after"}, 32'(bus.write), 32'd0);
        chk({tag, " done_after"}, 32'(bus.done), 32'd0);
        chk({tag, " flag_z"}, 32'(bus.flag_z), 32'(exp_z));
        chk({tag, " flag_c"}, 32'(bus.flag_c), 32'(exp_c));
        chk({tag, " rf_dest"}, 32'(rf[d]), (d == 5'd0) ? 32'h0 : 32'(exp_data));
    endtask

    initial begin
        reset           = 1'b1;
        rf_clr          = 1'b1;
        pre_we          = 1'b0;
        pre_addr        = 5'd0;
        pre_data        = 16'h0000;
        bus.instr_valid = 1'b0;
        bus.op          = 3'd0;
        bus.rd          = 5'd0;
        bus.rs          = 5'd0;
        bus.rt          = 5'd0;
        tick();
        tick();
        reset  = 1'b0;
        rf_clr = 1'b0;

        chk("rst ready", 32'(bus.instr_ready), 32'd1);
        chk("rst write", 32'(bus.write), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst flag_z", 32'(bus.flag_z), 32'd0);
        chk("rst flag_c", 32'(bus.flag_c), 32'd0);
        chk("rst wrData", 32'(bus.wrData), 32'd0);
        chk("rst wrAddr", 32'(bus.wrAddr), 32'd0);
        chk("rst rdAddrA", 32'(bus.rdAddrA), 32'd0);

        preload(5'd1, 16'hFFFF);
        preload(5'd2, 16'h0002);
        preload(5'd4, 16'h0005);
        preload(5'd5, 16'h0005);
        preload(5'd8, 16'h8001);
        preload(5'd9, 16'h0011);
        preload(5'd12, 16'h0123);
        preload(5'd13, 16'h0100);
        preload(5'd15, 16'h00FF);
        preload(5'd16, 16'h0002);
        preload(5'd18, 16'hF0F0);
        preload(5'd19, 16'hFF00);
        preload(5'd23, 16'h0001);

        run_op("add_carry", 3'b000, 5'd3, 5'd1, 5'd2, 16'h0001, 1'b0, 1'b1, 3);
        run_op("add_wrap0", 3'b000, 5'd24, 5'd1, 5'd23, 16'h0000, 1'b1, 1'b1, 3);
        run_op("sub_zero", 3'b001, 5'd6, 5'd4, 5'd5, 16'h0000, 1'b1, 1'b0, 3);
        run_op("sub_borrow", 3'b001, 5'd7, 5'd0, 5'd4, 16'hFFFB, 1'b0, 1'b1, 3);
        run_op("sll", 3'b101, 5'd10, 5'd8, 5'd9, 16'h0002, 1'b0, 1'b0, 3);
        run_op("srl", 3'b110, 5'd11, 5'd8, 5'd9, 16'h4000, 1'b0, 1'b0, 3);
        run_op("and", 3'b010, 5'd20, 5'd18, 5'd19, 16'hF000, 1'b0, 1'b0, 3);
        run_op("or", 3'b011, 5'd21, 5'd18, 5'd19, 16'hFFF0, 1'b0, 1'b0, 3);
        run_op("xor", 3'b100, 5'd22, 5'd18, 5'd19, 16'h0FF0, 1'b0, 1'b0, 3);
        run_op("mul_ovf", 3'b111, 5'd14, 5'd12, 5'd13, 16'h2300, 1'b0, 1'b1, 18);
        run_op("mul_small", 3'b111, 5'd17, 5'd15, 5'd16, 16'h01FE, 1'b0, 1'b0, 18);
        run_op("add_rd0", 3'b000, 5'd0, 5'd1, 5'd2, 16'h0001, 1'b0, 1'b1, 3);
        run_op("dep_1", 3'b000, 5'd2, 5'd2, 5'd2, 16'h0004, 1'b0, 1'b0, 3);
        run_op("dep_2", 3'b000, 5'd2, 5'd2, 5'd2, 16'h0008, 1'b0, 1'b0, 3);

        // Abort a MUL with a one-cycle reset at T+9.
        bus.instr_valid = 1'b1;
        bus.op = 3'b111;
        bus.rd = 5'd14;
        bus.rs = 5'd15;
        bus.rt = 5'd16;
        tick();
        bus.instr_valid = 1'b0;
        for (int i = 1; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort ready", 32'(bus.instr_ready), 32'd1);
        chk("abort write", 32'(bus.write), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort flag_z", 32'(bus.flag_z), 32'd0);
        chk("abort flag_c", 32'(bus.flag_c), 32'd0);
        chk("abort rdAddrA", 32'(bus.rdAddrA), 32'd0);
        chk("abort rdAddrB", 32'(bus.rdAddrB), 32'd0);
        chk("abort wrAddr", 32'(bus.wrAddr), 32'd0);
        chk("abort wrData", 32'(bus.wrData), 32'd0);
        for (int i = 0; i < 20; i++) begin
            chk("abort no_write", 32'(bus.write), 32'd0);
            tick();
        end
        chk("abort rf14", 32'(rf[14]), 32'h2300);

        // An instruction offered while reset is high must not be taken.
        bus.instr_valid = 1'b1;
        bus.op = 3'b000;
        bus.rd = 5'd25;
        bus.rs = 5'd1;
        bus.rt = 5'd23;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.instr_valid = 1'b0;
        chk("rstvalid ready", 32'(bus.instr_ready), 32'd1);
        chk("rstvalid rdAddrA", 32'(bus.rdAddrA), 32'd0);
        tick();
        chk("rstvalid ready2", 32'(bus.instr_ready), 32'd1);

        // Stage still works after the abort.
        run_op("post_abort", 3'b111, 5'd26, 5'd15, 5'd16, 16'h01FE, 1'b0, 1'b0, 18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
